// File: rtl/rf_pkg.sv
// Shared register-file types: widths, writeback payload, age encoding, mask helper.
//   RF_ADDR_W / RF_DATA_W : register index and data widths
//   wb_req_t              : writeback payload {addr, data}
//   age_e                 : relative age of the two arbiter holding buffers
package rf_pkg;

    localparam int unsigned RF_ADDR_W = 5;
    localparam int unsigned RF_DATA_W = 32;
    localparam int unsigned RF_REGS   = 2**RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;
    typedef logic [RF_REGS-1:0]   rf_mask_t;

    typedef struct packed {
        rf_addr_t addr;
        rf_data_t data;
    } wb_req_t;

    // Both-valid ordering: loaded on the same edge, or one strictly older.
    typedef enum logic [1:0] {
        AGE_TIE      = 2'd0,
        AGE_BUF0_OLD = 2'd1,
        AGE_BUF1_OLD = 2'd2
    } age_e;

    // One-hot register mask for a buffered write; empty when not valid.
    function automatic rf_mask_t addr_onehot(input rf_addr_t addr, input logic valid);
        addr_onehot = valid ? (rf_mask_t'(1) << addr) : '0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback request and register-file write-port bundle for regfile_write_arbiter.
//   req0_* / req1_* : valid/ready writeback requests from ALU (0) and long-latency unit (1)
//   we3/wa3/wd3     : register file write port
//   pend_mask       : registers with a buffered, not yet retired write
// master = writeback sources / register file side, slave = arbiter.
interface regfile_write_arbiter_if;
    import rf_pkg::*;

    logic     req0_valid;
    logic     req0_ready;
    rf_addr_t req0_addr;
    rf_data_t req0_data;
    logic     req1_valid;
    logic     req1_ready;
    rf_addr_t req1_addr;
    rf_data_t req1_data;
    logic     we3;
    rf_addr_t wa3;
    rf_data_t wd3;
    rf_mask_t pend_mask;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  we3, wa3, wd3, pend_mask
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output we3, wa3, wd3, pend_mask
    );

endinterface

// File: rtl/wb_hold_buf.sv
// Single-entry valid/ready holding register; writes to register 0 are accepted and dropped.
//   clk, reset_n : clock, async active-low reset (clears the entry)
//   in_valid     : request valid
//   in_ready     : entry empty (straight from the valid flop)
//   in_req       : request payload
//   clear        : entry retired this cycle, empties at the edge
//   out_valid    : entry holds a write
//   out_req      : held payload
//   load_c       : entry is being loaded at the coming edge
module wb_hold_buf
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    reset_n,
    input  logic    in_valid,
    output logic    in_ready,
    input  wb_req_t in_req,
    input  logic    clear,
    output logic    out_valid,
    output wb_req_t out_req,
    output logic    load_c
);

    logic    valid_q;
    wb_req_t req_q;

    // Handshake completes even for r0, but the entry is never filled for it.
    assign load_c = in_valid && !valid_q && (in_req.addr != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            req_q   <= '0;
        end else if (load_c) begin
            valid_q <= 1'b1;
            req_q   <= in_req;
        end else if (clear) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready  = !valid_q;
    assign out_valid = valid_q;
    assign out_req   = req_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between ALU writeback (source 0) and the
// long-latency unit (source 1). Each source has a one-entry holding buffer; one write
// retires per cycle, oldest first, ties broken round-robin (same-register ties go to
// source 0 so program order holds). Exports a pending-write mask for RAW stalls.
//   clk, reset_n : clock, async active-low reset (discards buffered writes)
//   bus          : request handshakes, write port and pend_mask (slave modport)
module regfile_write_arbiter
    import rf_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    regfile_write_arbiter_if.slave bus
);

    logic    buf0_valid, buf1_valid;
    logic    buf0_load, buf1_load;
    wb_req_t buf0_req, buf1_req;
    logic    grant0, grant1;
    logic    rr_ptr, rr_next;
    age_e    age_q, age_next;

    wb_hold_buf u_buf0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (bus.req0_valid),
        .in_ready  (bus.req0_ready),
        .in_req    ('{addr: bus.req0_addr, data: bus.req0_data}),
        .clear     (grant0),
        .out_valid (buf0_valid),
        .out_req   (buf0_req),
        .load_c    (buf0_load)
    );

    wb_hold_buf u_buf1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (bus.req1_valid),
        .in_ready  (bus.req1_ready),
        .in_req    ('{addr: bus.req1_addr, data: bus.req1_data}),
        .clear     (grant1),
        .out_valid (buf1_valid),
        .out_req   (buf1_req),
        .load_c    (buf1_load)
    );

    // Age and round-robin state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            age_q  <= AGE_TIE;
            rr_ptr <= 1'b0;
        end else begin
            age_q  <= age_next;
            rr_ptr <= rr_next;
        end
    end

    // A lone load makes the other buffer (if still held) the older one.
    always_comb begin
        age_next = age_q;
        if (buf0_load && buf1_load) begin
            age_next = AGE_TIE;
        end else if (buf0_load) begin
            age_next = AGE_BUF1_OLD;
        end else if (buf1_load) begin
            age_next = AGE_BUF0_OLD;
        end
    end

    // Grant from buffer state only; no request input reaches the write port.
    always_comb begin
        grant0  = 1'b0;
        grant1  = 1'b0;
        rr_next = rr_ptr;
        if (buf0_valid && buf1_valid) begin
            unique case (age_q)
                AGE_BUF0_OLD: grant0 = 1'b1;
                AGE_BUF1_OLD: grant1 = 1'b1;
                default: begin
                    if (buf0_req.addr == buf1_req.addr || !rr_ptr) begin
                        grant0  = 1'b1;
                        rr_next = 1'b1;
                    end else begin
                        grant1  = 1'b1;
                        rr_next = 1'b0;
                    end
                end
            endcase
        end else if (buf0_valid) begin
            grant0 = 1'b1;
        end else if (buf1_valid) begin
            grant1 = 1'b1;
        end
    end

    // Write port mux; zero when idle.
    always_comb begin
        bus.we3 = 1'b0;
        bus.wa3 = '0;
        bus.wd3 = '0;
        if (grant0) begin
            bus.we3 = 1'b1;
            bus.wa3 = buf0_req.addr;
            bus.wd3 = buf0_req.data;
        end else if (grant1) begin
            bus.we3 = 1'b1;
            bus.wa3 = buf1_req.addr;
            bus.wd3 = buf1_req.data;
        end
    end

    assign bus.pend_mask = addr_onehot(buf0_req.addr, buf0_valid)
                         | addr_onehot(buf1_req.addr, buf1_valid);

endmodule
